// File: rtl/uff_pkg.sv
// ============================================================================
// Module : uff_pkg
// Brief  : Shared mode encodings, S=R=1 policy constants and SR resolution
//          helper for the universal flip-flop register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } uff_mode_e;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;

    // Next state of one SR bit; the S=R=1 case is resolved by the static policy.
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input int policy);
        logic nxt;
        nxt = q;
        case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
                if (policy == POL_SET)
                    nxt = 1'b1;
                else if (policy == POL_RST)
                    nxt = 1'b0;
                else
                    nxt = q;
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uff_cell.sv
// ============================================================================
// Module : uff_cell
// Brief  : One bit of the universal register: SR/JK/D/T next-state function,
//          the storage flop and a per-bit S=R=1 collide flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uff_cell
    import uff_pkg::*;
#(
    parameter logic RESET_BIT  = 1'b0,
    parameter int   ILL_POLICY = POL_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    output logic       q,
    output logic       qbar,
    output logic       collide
);

    logic r_q;
    logic w_d;

    always_comb begin
        w_d = r_q;
        if (en) begin
            case (uff_mode_e'(mode))
                MODE_SR: w_d = sr_next(r_q, a, b, ILL_POLICY);
                MODE_JK: w_d = (a & ~r_q) | (~b & r_q);
                MODE_D:  w_d = a;
                MODE_T:  w_d = r_q ^ a;
                default: w_d = r_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= RESET_BIT;
        else
            r_q <= w_d;
    end

    // qbar is derived from the flop so it can never equal q, even in reset.
    assign q       = r_q;
    assign qbar    = ~r_q;
    assign collide = en & (mode == MODE_SR) & a & b;

endmodule

`default_nettype wire

// File: rtl/universal_ff_reg.sv
// ============================================================================
// Module : universal_ff_reg
// Brief  : WIDTH-bit edge-triggered SR/JK/D/T register with illegal S=R=1
//          detection, a sticky flag and a saturating error counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module universal_ff_reg
    import uff_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int               ILL_POLICY = POL_HOLD,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             illegal,
    output logic             illegal_sticky,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic [WIDTH-1:0] w_collide;
    logic             w_collide_any;
    logic             r_illegal;
    logic             r_sticky;
    logic [CNT_W-1:0] r_err_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        uff_cell #(
            .RESET_BIT  (RESET_VAL[i]),
            .ILL_POLICY (ILL_POLICY)
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .mode    (mode),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q[i]),
            .qbar    (qbar[i]),
            .collide (w_collide[i])
        );
    end

    // One event per edge no matter how many bits collide.
    assign w_collide_any = |w_collide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_sticky  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_illegal <= w_collide_any;
            // Clear has priority over a same-edge illegal event; the pulse itself still fires.
            if (cnt_clr) begin
                r_sticky  <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_collide_any) begin
                r_sticky <= 1'b1;
                if (r_err_cnt != C_CNT_MAX)
                    r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign illegal        = r_illegal;
    assign illegal_sticky = r_sticky;
    assign err_cnt        = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_universal_ff_reg.sv
// ============================================================================
// Module : tb_universal_ff_reg
// Brief  : Self-checking bench; three DUTs share stimulus, one per S=R=1 policy.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_universal_ff_reg;

    localparam logic [7:0] C_RST = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       cnt_clr;

    logic [7:0] q0, q1, q2, qb0, qb1, qb2;
    logic       ill0, ill1, ill2, st0, st1, st2;
    logic [3:0] cnt0, cnt1, cnt2;

    universal_ff_reg #(.WIDTH(8), .RESET_VAL(C_RST), .ILL_POLICY(0), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .cnt_clr(cnt_clr),
        .q(q0), .qbar(qb0), .illegal(ill0), .illegal_sticky(st0), .err_cnt(cnt0));
    universal_ff_reg #(.WIDTH(8), .RESET_VAL(C_RST), .ILL_POLICY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .cnt_clr(cnt_clr),
        .q(q1), .qbar(qb1), .illegal(ill1), .illegal_sticky(st1), .err_cnt(cnt1));
    universal_ff_reg #(.WIDTH(8), .RESET_VAL(C_RST), .ILL_POLICY(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .cnt_clr(cnt_clr),
        .q(q2), .qbar(qb2), .illegal(ill2), .illegal_sticky(st2), .err_cnt(cnt2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] q0;
        logic [7:0] q1;
        logic [7:0] q2;
        logic       ill;
        logic       sticky;
        logic [3:0] cnt;
    } exp_t;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic       clr;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[12];

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] m_q[3];
    logic       m_sticky;
    logic [3:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] q, input logic e,
                                            input logic [1:0] md, input logic [7:0] s,
                                            input logic [7:0] r, input int pol);
        logic [7:0] n;
        n = q;
        if (e) begin
            for (int i = 0; i < 8; i++) begin
                case (md)
                    2'd0: begin
                        if (s[i] && !r[i])      n[i] = 1'b1;
                        else if (!s[i] && r[i]) n[i] = 1'b0;
                        else if (s[i] && r[i])  n[i] = (pol == 1) ? 1'b1 : (pol == 2) ? 1'b0 : q[i];
                    end
                    2'd1: n[i] = (s[i] & ~q[i]) | (~r[i] & q[i]);
                    2'd2: n[i] = s[i];
                    default: n[i] = q[i] ^ s[i];
                endcase
            end
        end
        return n;
    endfunction

    task automatic model_step(input logic e, input logic [1:0] md, input logic [7:0] s,
                              input logic [7:0] r, input logic clr, output exp_t x);
        logic ill;
        ill = e && (md == 2'd0) && ((s & r) != 8'h00);
        for (int p = 0; p < 3; p++)
            m_q[p] = ref_next(m_q[p], e, md, s, r, p);
        if (clr) begin
            m_sticky = 1'b0;
            m_cnt    = 4'h0;
        end else if (ill) begin
            m_sticky = 1'b1;
            if (m_cnt != 4'hF)
                m_cnt = m_cnt + 4'h1;
        end
        x = '{q0: m_q[0], q1: m_q[1], q2: m_q[2], ill: ill, sticky: m_sticky, cnt: m_cnt};
    endtask

    task automatic model_reset();
        for (int p = 0; p < 3; p++)
            m_q[p] = C_RST;
        m_sticky = 1'b0;
        m_cnt    = 4'h0;
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk("q_hold",  {24'd0, q0},  {24'd0, e.q0});
        chk("qb_hold", {24'd0, qb0}, {24'd0, ~e.q0});
        chk("q_set",   {24'd0, q1},  {24'd0, e.q1});
        chk("qb_set",  {24'd0, qb1}, {24'd0, ~e.q1});
        chk("q_rst",   {24'd0, q2},  {24'd0, e.q2});
        chk("qb_rst",  {24'd0, qb2}, {24'd0, ~e.q2});
        chk("illegal", {29'd0, ill0, ill1, ill2}, {29'd0, {3{e.ill}}});
        chk("sticky",  {29'd0, st0, st1, st2},    {29'd0, {3{e.sticky}}});
        chk("err_cnt", {20'd0, cnt0, cnt1, cnt2}, {20'd0, {3{e.cnt}}});
    endtask

    task automatic drive(input logic e, input logic [1:0] md, input logic [7:0] s,
                         input logic [7:0] r, input logic clr);
        en      = e;
        mode    = md;
        a       = s;
        b       = r;
        cnt_clr = clr;
    endtask

    // Drive one edge, expected values come from the reference model.
    task automatic step(input logic e, input logic [1:0] md, input logic [7:0] s,
                        input logic [7:0] r, input logic clr);
        exp_t x;
        drive(e, md, s, r, clr);
        model_step(e, md, s, r, clr, x);
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        exp_t dummy;

        //            en  mode   a      b      clr  q0     q1     q2     ill   st    cnt
        tbl[0]  = '{1'b1, 2'd0, 8'h0F, 8'hF0, 1'b0, '{8'h0F, 8'h0F, 8'h0F, 1'b0, 1'b0, 4'd0}};
        tbl[1]  = '{1'b1, 2'd0, 8'h01, 8'h01, 1'b0, '{8'h0F, 8'h0F, 8'h0E, 1'b1, 1'b1, 4'd1}};
        tbl[2]  = '{1'b1, 2'd0, 8'h10, 8'h10, 1'b0, '{8'h0F, 8'h1F, 8'h0E, 1'b1, 1'b1, 4'd2}};
        tbl[3]  = '{1'b1, 2'd2, 8'h0F, 8'hFF, 1'b0, '{8'h0F, 8'h0F, 8'h0F, 1'b0, 1'b1, 4'd2}};
        tbl[4]  = '{1'b1, 2'd1, 8'hFF, 8'hFF, 1'b0, '{8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b1, 4'd2}};
        tbl[5]  = '{1'b1, 2'd3, 8'h81, 8'hFF, 1'b0, '{8'h71, 8'h71, 8'h71, 1'b0, 1'b1, 4'd2}};
        tbl[6]  = '{1'b1, 2'd2, 8'h5A, 8'h00, 1'b0, '{8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 4'd2}};
        tbl[7]  = '{1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0, '{8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b1, 4'd2}};
        tbl[8]  = '{1'b1, 2'd1, 8'hF0, 8'h0F, 1'b0, '{8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b1, 4'd2}};
        tbl[9]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b0, '{8'hF0, 8'hF0, 8'hF0, 1'b0, 1'b1, 4'd2}};
        tbl[10] = '{1'b1, 2'd3, 8'hFF, 8'h00, 1'b0, '{8'h0F, 8'h0F, 8'h0F, 1'b0, 1'b1, 4'd2}};
        tbl[11] = '{1'b1, 2'd2, 8'h33, 8'h00, 1'b1, '{8'h33, 8'h33, 8'h33, 1'b0, 1'b0, 4'd0}};

        rst_n = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_q",   {8'd0, q0, q1, q2},    {8'd0, {3{C_RST}}});
        chk("reset_qb",  {8'd0, qb0, qb1, qb2}, {8'd0, {3{~C_RST}}});
        chk("reset_cnt", {20'd0, cnt0, cnt1, cnt2}, 32'd0);
        chk("reset_flags", {26'd0, ill0, ill1, ill2, st0, st1, st2}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr);
            model_step(tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr, dummy);
            sb.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            check_out();
        end

        // Asynchronous reset mid-cycle with q=3C and a nonzero counter.
        step(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        step(1'b1, 2'd2, 8'h3C, 8'h00, 1'b0);
        chk("pre_reset_q", {24'd0, q0}, 32'h3C);
        #3 rst_n = 1'b0;
        #1;
        chk("async_q",    {8'd0, q0, q1, q2},    {8'd0, {3{8'hA5}}});
        chk("async_qb",   {8'd0, qb0, qb1, qb2}, {8'd0, {3{8'h5A}}});
        chk("async_cnt",  {20'd0, cnt0, cnt1, cnt2}, 32'd0);
        chk("async_flag", {26'd0, ill0, ill1, ill2, st0, st1, st2}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        step(1'b0, 2'd3, 8'hFF, 8'h00, 1'b0);

        // Saturation, then clear racing an illegal edge.
        for (int i = 0; i < 20; i++)
            step(1'b1, 2'd0, 8'h01, 8'h01, 1'b0);
        chk("sat_cnt",    {28'd0, cnt0}, 32'hF);
        chk("sat_sticky", {31'd0, st0},  32'd1);
        step(1'b1, 2'd0, 8'h81, 8'h81, 1'b1);
        chk("clr_cnt",    {28'd0, cnt0}, 32'd0);
        chk("clr_sticky", {31'd0, st0},  32'd0);
        chk("clr_ill",    {31'd0, ill0}, 32'd1);
        step(1'b0, 2'd0, 8'hFF, 8'hFF, 1'b0);
        chk("ill_drop",   {31'd0, ill0}, 32'd0);

        // Random traffic against the reference model.
        for (int i = 0; i < 10000; i++)
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
